snapshot_ctrl: RTL and testbench

Sequences one snapshot capture of the ADC sample stream into the snapshot buffer RAM. It is driven by the CSR control outputs (stream enable, snapshot length) and the alignment lock status. It writes `snap_len` aligned samples to consecutive buffer addresses, then raises `snapshot_done` for the CSR status register. It sits between the aligner output, the snapshot buffer write port and the CSR block.

---
 rtl/snapshot_ctrl.sv | 161 ++++++++++++++++
 tb/tb_snapshot_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snapshot_ctrl.sv
// Snapshot capture sequencer: arms on a rising stream_enable, waits for aligner lock,
// then writes snap_len samples (clamped to buffer depth) to consecutive buffer addresses.
module snapshot_ctrl #(
   parameter int DATA_W     = 16,
   parameter int BUF_ADDR_W = 10,
   parameter int LEN_W      = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  stream_enable,
   input  logic [LEN_W-1:0]      snap_len,
   input  logic                  align_locked,
   input  logic                  in_valid,
   input  logic [DATA_W-1:0]     in_data,
   output logic                  buf_wr_en,
   output logic [BUF_ADDR_W-1:0] buf_wr_addr,
   output logic [DATA_W-1:0]     buf_wr_data,
   output logic                  snapshot_done,
   output logic                  busy,
   output logic [BUF_ADDR_W:0]   snap_count,
   output logic                  len_clamped,
   output logic                  lock_lost
);

   localparam int CNT_W = BUF_ADDR_W + 1;
   localparam logic [LEN_W-1:0] DEPTH = LEN_W'(2 ** BUF_ADDR_W);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ARM     = 2'd1,
      S_CAPTURE = 2'd2,
      S_DONE    = 2'd3
   } state_t;

   state_t                state_q, state_d;
   logic                  en_q, en_d;
   logic [CNT_W-1:0]      len_q, len_d;
   logic [CNT_W-1:0]      snap_count_q, snap_count_d;
   logic                  len_clamped_q, len_clamped_d;
   logic                  lock_lost_q, lock_lost_d;
   logic                  wr_en_q, wr_en_d;
   logic [BUF_ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0]     wr_data_q, wr_data_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;

   logic                  arm_evt;
   logic                  clamp;
   logic [CNT_W-1:0]      len_sel;
   logic [CNT_W-1:0]      count_inc;

   assign arm_evt   = stream_enable & ~en_q;
   assign clamp     = (snap_len > DEPTH);
   assign len_sel   = clamp ? DEPTH[CNT_W-1:0] : snap_len[CNT_W-1:0];
   assign count_inc = snap_count_q + CNT_W'(1);

   always_comb begin
      state_d       = state_q;
      en_d          = stream_enable;
      len_d         = len_q;
      snap_count_d  = snap_count_q;
      len_clamped_d = len_clamped_q;
      lock_lost_d   = lock_lost_q;
      wr_en_d       = 1'b0;
      wr_addr_d     = wr_addr_q;
      wr_data_d     = wr_data_q;

      case (state_q)
         S_IDLE: begin
            if (arm_evt) begin
               len_d         = len_sel;
               len_clamped_d = clamp;
               lock_lost_d   = 1'b0;
               snap_count_d  = '0;
               state_d       = (snap_len == '0) ? S_DONE : S_ARM;
            end
         end
         S_ARM: begin
            // Samples arriving while waiting for lock are dropped on purpose.
            if (!stream_enable) begin
               state_d = S_IDLE;
            end else if (align_locked) begin
               state_d = S_CAPTURE;
            end
         end
         S_CAPTURE: begin
            if (!stream_enable) begin
               state_d = S_IDLE;
            end else if (!align_locked) begin
               // A capture interrupted by lock loss restarts from address 0.
               lock_lost_d  = 1'b1;
               snap_count_d = '0;
               state_d      = S_ARM;
            end else if (in_valid) begin
               wr_en_d      = 1'b1;
               wr_addr_d    = snap_count_q[BUF_ADDR_W-1:0];
               wr_data_d    = in_data;
               snap_count_d = count_inc;
               if (count_inc == len_q) begin
                  state_d = S_DONE;
               end
            end
         end
         S_DONE: begin
            if (!stream_enable) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d == S_ARM) || (state_d == S_CAPTURE);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         en_q          <= 1'b0;
         len_q         <= '0;
         snap_count_q  <= '0;
         len_clamped_q <= 1'b0;
         lock_lost_q   <= 1'b0;
         wr_en_q       <= 1'b0;
         wr_addr_q     <= '0;
         wr_data_q     <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         en_q          <= en_d;
         len_q         <= len_d;
         snap_count_q  <= snap_count_d;
         len_clamped_q <= len_clamped_d;
         lock_lost_q   <= lock_lost_d;
         wr_en_q       <= wr_en_d;
         wr_addr_q     <= wr_addr_d;
         wr_data_q     <= wr_data_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
      end
   end

   assign buf_wr_en     = wr_en_q;
   assign buf_wr_addr   = wr_addr_q;
   assign buf_wr_data   = wr_data_q;
   assign snapshot_done = done_q;
   assign busy          = busy_q;
   assign snap_count    = snap_count_q;
   assign len_clamped   = len_clamped_q;
   assign lock_lost     = lock_lost_q;

   a_busy_done_excl: assert property (@(posedge clk) disable iff (!rst_n)
      !(busy_q && done_q));

   a_count_in_range: assert property (@(posedge clk) disable iff (!rst_n)
      snap_count_q <= len_q || state_q == S_IDLE);

endmodule

// File: tb/tb_snapshot_ctrl.sv
// Bench for snapshot_ctrl: directed scenarios plus randomized traffic, checked each cycle
// against a behavioural model and a write scoreboard.
module tb_snapshot_ctrl;

   localparam int DW    = 16;
   localparam int AW    = 3;
   localparam int LW    = 32;
   localparam int DEPTH = 8;

   logic          clk;
   logic          rst_n;
   logic          stream_enable;
   logic [LW-1:0] snap_len;
   logic          align_locked;
   logic          in_valid;
   logic [DW-1:0] in_data;
   logic          buf_wr_en;
   logic [AW-1:0] buf_wr_addr;
   logic [DW-1:0] buf_wr_data;
   logic          snapshot_done;
   logic          busy;
   logic [AW:0]   snap_count;
   logic          len_clamped;
   logic          lock_lost;

   snapshot_ctrl #(.DATA_W(DW), .BUF_ADDR_W(AW), .LEN_W(LW)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .stream_enable (stream_enable),
      .snap_len      (snap_len),
      .align_locked  (align_locked),
      .in_valid      (in_valid),
      .in_data       (in_data),
      .buf_wr_en     (buf_wr_en),
      .buf_wr_addr   (buf_wr_addr),
      .buf_wr_data   (buf_wr_data),
      .snapshot_done (snapshot_done),
      .busy          (busy),
      .snap_count    (snap_count),
      .len_clamped   (len_clamped),
      .lock_lost     (lock_lost)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- bookkeeping ----------------
   int n_tests = 0;
   int n_fail  = 0;
   int n_wr    = 0;

   logic [AW+DW-1:0] exp_q[$];

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // phase: 0 idle, 1 waiting for lock, 2 collecting samples, 3 finished
   int          m_phase;
   bit          m_en_prev;
   int          m_len;
   int          m_cnt;
   bit          m_clamp;
   bit          m_lost;
   bit          m_wr;
   int          m_addr;
   logic [DW-1:0] m_data;

   task automatic model_reset();
      m_phase   = 0;
      m_en_prev = 0;
      m_len     = 0;
      m_cnt     = 0;
      m_clamp   = 0;
      m_lost    = 0;
      m_wr      = 0;
      m_addr    = 0;
      m_data    = '0;
      exp_q.delete();
   endtask

   task automatic model_step();
      logic [AW+DW-1:0] e;
      m_wr = 0;
      if (m_phase == 0) begin
         if (stream_enable && !m_en_prev) begin
            m_clamp = (snap_len > DEPTH);
            m_len   = m_clamp ? DEPTH : int'(snap_len);
            m_lost  = 0;
            m_cnt   = 0;
            m_phase = (snap_len == 0) ? 3 : 1;
         end
      end else if (m_phase == 1) begin
         if (!stream_enable) m_phase = 0;
         else if (align_locked) m_phase = 2;
      end else if (m_phase == 2) begin
         if (!stream_enable) m_phase = 0;
         else if (!align_locked) begin
            m_lost  = 1;
            m_cnt   = 0;
            m_phase = 1;
         end else if (in_valid) begin
            m_wr   = 1;
            m_addr = m_cnt;
            m_data = in_data;
            e = {m_addr[AW-1:0], in_data};
            exp_q.push_back(e);
            m_cnt++;
            if (m_cnt == m_len) m_phase = 3;
         end
      end else begin
         if (!stream_enable) m_phase = 0;
      end
      m_en_prev = stream_enable;
   endtask

   task automatic check_all();
      logic [AW+DW-1:0] e;
      check_eq("wr_en", buf_wr_en, m_wr);
      if (m_wr) begin
         check_eq("wr_addr", buf_wr_addr, m_addr[AW-1:0]);
         check_eq("wr_data", buf_wr_data, m_data);
      end
      check_eq("done", snapshot_done, m_phase == 3);
      check_eq("busy", busy, (m_phase == 1) || (m_phase == 2));
      check_eq("snap_count", snap_count, m_cnt);
      check_eq("len_clamped", len_clamped, m_clamp);
      check_eq("lock_lost", lock_lost, m_lost);
      if (buf_wr_en === 1'b1) begin
         n_wr++;
         check_eq("sb_pending", exp_q.size() != 0, 1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check_eq("sb_write", {buf_wr_addr, buf_wr_data}, e);
         end
      end
   endtask

   task automatic check_zero(input string tag);
      check_eq({tag, "_wr_en"}, buf_wr_en, 0);
      check_eq({tag, "_wr_addr"}, buf_wr_addr, 0);
      check_eq({tag, "_wr_data"}, buf_wr_data, 0);
      check_eq({tag, "_done"}, snapshot_done, 0);
      check_eq({tag, "_busy"}, busy, 0);
      check_eq({tag, "_count"}, snap_count, 0);
      check_eq({tag, "_clamped"}, len_clamped, 0);
      check_eq({tag, "_lost"}, lock_lost, 0);
   endtask

   // ---------------- driver ----------------
   task automatic cycle(input bit en, input int len, input bit lock, input bit vld,
                        input logic [DW-1:0] d);
      @(negedge clk);
      stream_enable = en;
      snap_len      = len;
      align_locked  = lock;
      in_valid      = vld;
      in_data       = d;
      @(posedge clk);
      model_step();
      #1;
      check_all();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      int w0;
      bit en_r;
      rst_n         = 1'b0;
      stream_enable = 1'b0;
      snap_len      = '0;
      align_locked  = 1'b0;
      in_valid      = 1'b0;
      in_data       = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // basic capture
      cycle(0, 4, 1, 0, 0);
      w0 = n_wr;
      for (int i = 0; i < 8; i++) cycle(1, 4, 1, 1, DW'(16'h1000 + i));
      check_eq("basic_writes", n_wr - w0, 4);
      check_eq("basic_done", snapshot_done, 1);
      check_eq("basic_count", snap_count, 4);

      // zero length
      cycle(0, 0, 1, 1, 0);
      w0 = n_wr;
      cycle(1, 0, 1, 1, 16'h2222);
      check_eq("zero_done", snapshot_done, 1);
      for (int i = 0; i < 3; i++) cycle(1, 0, 1, 1, 16'h2223);
      check_eq("zero_writes", n_wr - w0, 0);
      check_eq("zero_count", snap_count, 0);

      // clamp, with snap_len changed after arm
      cycle(0, 20, 1, 0, 0);
      w0 = n_wr;
      for (int i = 0; i < 14; i++) cycle(1, (i == 0) ? 20 : 3, 1, 1, DW'($urandom));
      check_eq("clamp_writes", n_wr - w0, DEPTH);
      check_eq("clamp_flag", len_clamped, 1);
      check_eq("clamp_done", snapshot_done, 1);

      // lock loss
      cycle(0, 6, 1, 0, 0);
      w0 = n_wr;
      for (int i = 0; i < 5; i++) cycle(1, 6, 1, 1, DW'(16'h3000 + i));
      check_eq("lost_clear_before", lock_lost, 0);
      for (int i = 0; i < 2; i++) cycle(1, 6, 0, 1, 16'h3333);
      check_eq("lost_flag", lock_lost, 1);
      check_eq("lost_count_reset", snap_count, 0);
      for (int i = 0; i < 10; i++) cycle(1, 6, 1, 1, DW'(16'h3100 + i));
      check_eq("lost_writes", n_wr - w0, 9);
      check_eq("lost_done", snapshot_done, 1);
      check_eq("lost_count", snap_count, 6);

      // abort, no re-arm while held, then fresh edge
      cycle(0, 5, 1, 0, 0);
      w0 = n_wr;
      for (int i = 0; i < 4; i++) cycle(1, 5, 1, 1, DW'(16'h4000 + i));
      for (int i = 0; i < 3; i++) cycle(0, 5, 1, 1, 16'h4444);
      check_eq("abort_writes", n_wr - w0, 2);
      check_eq("abort_done", snapshot_done, 0);
      check_eq("abort_busy", busy, 0);
      w0 = n_wr;
      for (int i = 0; i < 7; i++) cycle(1, 3, 1, 1, DW'(16'h4100 + i));
      for (int i = 0; i < 5; i++) cycle(1, 3, 1, 1, 16'h4555);
      check_eq("hold_writes", n_wr - w0, 3);
      check_eq("hold_done", snapshot_done, 1);
      cycle(0, 2, 1, 1, 0);
      check_eq("rearm_done_clear", snapshot_done, 0);
      w0 = n_wr;
      for (int i = 0; i < 6; i++) cycle(1, 2, 1, 1, DW'(16'h4200 + i));
      check_eq("rearm_writes", n_wr - w0, 2);

      // randomized traffic
      en_r = 0;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 19) == 0) en_r = ~en_r;
         cycle(en_r, $urandom_range(0, 12), $urandom_range(0, 15) != 0,
               $urandom_range(0, 3) != 0, DW'($urandom));
      end

      // asynchronous reset mid-capture
      cycle(0, 8, 1, 0, 0);
      for (int i = 0; i < 4; i++) cycle(1, 8, 1, 1, DW'(16'h5000 + i));
      @(negedge clk);
      #2;
      rst_n         = 1'b0;
      stream_enable = 1'b0;
      #1;
      model_reset();
      check_zero("async_rst");
      w0 = n_wr;
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_hold_wr_en", buf_wr_en, 0);
      check_eq("rst_hold_busy", busy, 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) cycle(0, 8, 1, 1, 16'h5555);
      check_eq("post_rst_writes", n_wr - w0, 0);

      check_eq("sb_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
